// File: rtl/enoc_switch_allocator.sv
// Switch allocator for the 5-port ENoC router: one round-robin arbiter per output,
// combinational FIFO pops, registered crossbar selects. Optional grant counters: ENOC_ALLOC_STATS_EN.
module enoc_switch_allocator #(
  parameter int N     = 5,
  parameter int M     = 5,
  parameter int CNT_W = 16,
  localparam int PW   = (M > 1) ? $clog2(M) : 1,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N-1:0]               i_req_val,
  input  logic [N-1:0][PW-1:0]       i_req_port,
  input  logic [M-1:0]               i_en,
  output logic [N-1:0]               o_pop,
  output logic [M-1:0][SW-1:0]       o_sel,
  output logic [M-1:0]               o_sel_val,
  output logic [M-1:0][CNT_W-1:0]    o_grant_cnt
);

  logic [M-1:0][N-1:0]  req;
  logic [M-1:0]         grant;
  logic [M-1:0][SW-1:0] win_idx;
  logic [M-1:0][SW-1:0] ptr_reg, ptr_next;
  logic [M-1:0][SW-1:0] sel_reg, sel_next;
  logic [M-1:0]         sel_val_reg, sel_val_next;
  logic [N-1:0]         pop_raw;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N) ? s - N : s;
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < M; gi++) begin : g_out
      logic             arb_grant;
      logic [SW-1:0]    arb_win;

      for (gj = 0; gj < N; gj++) begin : g_req
        assign req[gi][gj] = i_req_val[gj] && (i_req_port[gj] == PW'(gi));
      end

      // Scan from the farthest offset down so the last hit is the first input at or after ptr.
      always_comb begin
        arb_grant = 1'b0;
        arb_win   = '0;
        for (int k = N - 1; k >= 0; k--) begin
          if (i_en[gi] && req[gi][wrap_idx(int'(ptr_reg[gi]), k)]) begin
            arb_grant = 1'b1;
            arb_win   = SW'(wrap_idx(int'(ptr_reg[gi]), k));
          end
        end
      end

      assign grant[gi]   = arb_grant;
      assign win_idx[gi] = arb_win;
    end
  endgenerate

  // Each input requests a single port, so OR-ing the per-output one-hots never double-pops.
  always_comb begin
    pop_raw = '0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        if (grant[m] && (win_idx[m] == SW'(n))) begin
          pop_raw[n] = 1'b1;
        end
      end
    end
  end

  assign o_pop = reset_n ? pop_raw : '0;

  always_comb begin
    ptr_next     = ptr_reg;
    sel_next     = sel_reg;
    sel_val_next = grant;
    for (int m = 0; m < M; m++) begin
      if (grant[m]) begin
        sel_next[m] = win_idx[m];
        ptr_next[m] = (win_idx[m] == SW'(N - 1)) ? '0 : win_idx[m] + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg     <= '0;
      sel_reg     <= '0;
      sel_val_reg <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
      sel_val_reg <= sel_val_next;
    end
  end

  assign o_sel     = sel_reg;
  assign o_sel_val = sel_val_reg;

`ifdef ENOC_ALLOC_STATS_EN
  logic [M-1:0][CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    for (int m = 0; m < M; m++) begin
      if (grant[m] && (cnt_reg[m] != {CNT_W{1'b1}})) begin
        cnt_next[m] = cnt_reg[m] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign o_grant_cnt = cnt_reg;
`else
  assign o_grant_cnt = '0;
`endif

`ifndef SYNTHESIS
  // A head routed to a nonexistent port stalls forever; flag it loudly in simulation.
  always @(posedge clk) begin
    if (reset_n) begin
      for (int n = 0; n < N; n++) begin
        assert (!(i_req_val[n] && (int'(i_req_port[n]) >= M)))
          else $warning("enoc_switch_allocator: input %0d requests illegal port %0d", n, i_req_port[n]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Randomized and directed bench for enoc_switch_allocator against a queue-free
// round-robin reference model (pointer per output, scan-from-pointer rule).
module tb_enoc_switch_allocator;
  localparam int N     = 5;
  localparam int M     = 5;
  localparam int CNT_W = 2;
  localparam int PW    = 3;
  localparam int SW    = 3;

  typedef logic [M-1:0][SW-1:0]    sel_t;
  typedef logic [M-1:0][CNT_W-1:0] cnt_t;
  typedef logic [N-1:0][PW-1:0]    port_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] i_req_val;
  port_t        i_req_port;
  logic [M-1:0] i_en;
  logic [N-1:0] o_pop;
  sel_t         o_sel;
  logic [M-1:0] o_sel_val;
  cnt_t         o_grant_cnt;

  enoc_switch_allocator #(.N(N), .M(M), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req_val  (i_req_val),
    .i_req_port (i_req_port),
    .i_en       (i_en),
    .o_pop      (o_pop),
    .o_sel      (o_sel),
    .o_sel_val  (o_sel_val),
    .o_grant_cnt(o_grant_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  int           m_ptr[M];
  int           m_sel[M];
  bit           m_val[M];
  int           m_cnt[M];
  int           win[M];
  logic [N-1:0] exp_pop;
  logic [N-1:0] obs_pop;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      m_ptr[m] = 0; m_sel[m] = 0; m_val[m] = 1'b0; m_cnt[m] = 0;
    end
  endtask

  task automatic model_eval();
    exp_pop = '0;
    for (int m = 0; m < M; m++) begin
      win[m] = -1;
      if (i_en[m]) begin
        for (int k = 0; k < N; k++) begin
          int n;
          n = (m_ptr[m] + k) % N;
          if (win[m] < 0 && i_req_val[n] && int'(i_req_port[n]) == m) win[m] = n;
        end
      end
      if (win[m] >= 0) exp_pop[win[m]] = 1'b1;
    end
  endtask

  task automatic model_commit();
    for (int m = 0; m < M; m++) begin
      if (win[m] >= 0) begin
        m_sel[m] = win[m];
        m_val[m] = 1'b1;
        m_ptr[m] = (win[m] + 1) % N;
        if (m_cnt[m] < (1 << CNT_W) - 1) m_cnt[m]++;
      end else begin
        m_val[m] = 1'b0;
      end
    end
  endtask

  function automatic sel_t exp_sel();
    sel_t v;
    for (int m = 0; m < M; m++) v[m] = SW'(m_sel[m]);
    return v;
  endfunction

  function automatic logic [M-1:0] exp_sel_val();
    logic [M-1:0] v;
    for (int m = 0; m < M; m++) v[m] = m_val[m];
    return v;
  endfunction

  function automatic cnt_t exp_cnt();
    cnt_t v;
    for (int m = 0; m < M; m++) begin
`ifdef ENOC_ALLOC_STATS_EN
      v[m] = CNT_W'(m_cnt[m]);
`else
      v[m] = '0;
`endif
    end
    return v;
  endfunction

  // one allocation cycle: drive, check pops before the edge, check registers after it
  task automatic step(input logic [N-1:0] val, input port_t port, input logic [M-1:0] en, input string tag);
    i_req_val  = val;
    i_req_port = port;
    i_en       = en;
    #1;
    model_eval();
    obs_pop = o_pop;
    check_eq({tag, ".pop"}, 64'(o_pop), 64'(exp_pop));
    @(posedge clk);
    model_commit();
    #1;
    check_eq({tag, ".sel"}, 64'(o_sel), 64'(exp_sel()));
    check_eq({tag, ".sel_val"}, 64'(o_sel_val), 64'(exp_sel_val()));
    check_eq({tag, ".cnt"}, 64'(o_grant_cnt), 64'(exp_cnt()));
  endtask

  function automatic port_t all_ports(input int p);
    port_t v;
    for (int n = 0; n < N; n++) v[n] = PW'(p);
    return v;
  endfunction

  initial begin
    port_t        pp;
    logic [N-1:0] vv;
    logic [M-1:0] ee;
    int           rr_exp[6] = '{0, 1, 4, 0, 1, 4};

    // reset with requests active
    reset_n    = 1'b0;
    i_req_val  = '1;
    i_req_port = '0;
    for (int n = 0; n < N; n++) i_req_port[n] = PW'(n);
    i_en = '1;
    model_reset();
    #1;
    check_eq("rst.pop", 64'(o_pop), 64'(0));
    check_eq("rst.sel_val", 64'(o_sel_val), 64'(0));
    @(posedge clk); #1;
    check_eq("rst.sel", 64'(o_sel), 64'(0));
    check_eq("rst.cnt", 64'(o_grant_cnt), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // first request after reset
    pp = all_ports(0); pp[2] = 3'd3;
    step(5'b00100, pp, '1, "first");
    check_eq("first.pop2", 64'(obs_pop), 64'(5'b00100));
    check_eq("first.sel3", 64'(o_sel[3]), 64'(2));
    check_eq("first.val3", 64'(o_sel_val[3]), 64'(1));

    // round robin on output 2 among inputs 0, 1, 4
    pp = all_ports(2);
    for (int i = 0; i < 6; i++) begin
      step(5'b10011, pp, '1, "rr");
      check_eq("rr.sel2", 64'(o_sel[2]), 64'(rr_exp[i]));
    end

    // backpressure on output 0
    pp = all_ports(0);
    for (int i = 0; i < 4; i++) begin
      step(5'b00010, pp, 5'b11110, "bp");
      check_eq("bp.pop1", 64'(obs_pop[1]), 64'(0));
      check_eq("bp.val0", 64'(o_sel_val[0]), 64'(0));
    end
    step(5'b00010, pp, '1, "bp_rel");
    check_eq("bp_rel.pop1", 64'(obs_pop[1]), 64'(1));
    check_eq("bp_rel.sel0", 64'(o_sel[0]), 64'(1));

    // parallel grants, input n -> output 4-n
    for (int n = 0; n < N; n++) pp[n] = PW'(4 - n);
    step('1, pp, '1, "par");
    check_eq("par.pop", 64'(obs_pop), 64'(5'b11111));
    check_eq("par.sel", 64'(o_sel), 64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
    check_eq("par.val", 64'(o_sel_val), 64'(5'b11111));

    // illegal port on input 3
    pp = all_ports(0); pp[3] = 3'd6;
    step(5'b01000, pp, '1, "illegal");
    check_eq("illegal.pop", 64'(obs_pop), 64'(0));
    check_eq("illegal.val", 64'(o_sel_val), 64'(0));

    // five grants on output 1 drive the counter into saturation when enabled
    pp = all_ports(1);
    for (int i = 0; i < 5; i++) step(5'b00001, pp, '1, "stats");
`ifdef ENOC_ALLOC_STATS_EN
    check_eq("stats.cnt1", 64'(o_grant_cnt[1]), 64'(3));
`else
    check_eq("stats.cnt1", 64'(o_grant_cnt[1]), 64'(0));
`endif

    // randomized traffic with legal ports
    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < N; n++) pp[n] = PW'($urandom_range(0, M - 1));
      vv = N'($urandom);
      ee = M'($urandom | $urandom);
      step(vv, pp, ee, "rand");
    end

    // reset in the middle of a busy cycle drops in-flight selects at once
    step('1, all_ports(0), '1, "pre_rst");
    for (int n = 0; n < N; n++) pp[n] = PW'(n);
    i_req_val = '1; i_req_port = pp; i_en = '1;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("midrst.sel_val", 64'(o_sel_val), 64'(0));
    check_eq("midrst.sel", 64'(o_sel), 64'(0));
    check_eq("midrst.pop", 64'(o_pop), 64'(0));
    check_eq("midrst.cnt", 64'(o_grant_cnt), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      for (int n = 0; n < N; n++) pp[n] = PW'($urandom_range(0, M - 1));
      vv = N'($urandom);
      ee = M'($urandom | $urandom);
      step(vv, pp, ee, "rand2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
